// File: rtl/quan_block_scheduler.sv
// quan_block_scheduler
// Captures one quantized Y/U/V MCU triple from the quantizer into a single-slot
// buffer and replays it as three block transfers (Y, U, V) over valid/ready.
// o_wait stalls the quantizer while the buffer still holds blocks to send.
// Ports:
//   clk, n_rst            clock, synchronous active-low reset
//   i_quan_valid/_y/_u/_v quantizer MCU triple, i_last marks last MCU of image
//   o_wait                stall back to the quantizer
//   o_blk_valid/i_blk_ready  block handshake
//   o_blk_data/_comp/_last   block payload, component ID (0=Y,1=U,2=V), end of image
//   o_mcu_idx             index of the MCU currently presented
module quan_block_scheduler #(
  parameter int MCU_SIZE      = 8,
  parameter int QUAN_BITWIDTH = 12,
  parameter int MCU_CNT_WIDTH = 16
) (
  input  logic                                                     clk,
  input  logic                                                     n_rst,
  input  logic                                                     i_quan_valid,
  input  logic signed [MCU_SIZE-1:0][MCU_SIZE-1:0][QUAN_BITWIDTH-1:0] i_quan_y,
  input  logic signed [MCU_SIZE-1:0][MCU_SIZE-1:0][QUAN_BITWIDTH-1:0] i_quan_u,
  input  logic signed [MCU_SIZE-1:0][MCU_SIZE-1:0][QUAN_BITWIDTH-1:0] i_quan_v,
  input  logic                                                     i_last,
  output logic                                                     o_wait,
  output logic                                                     o_blk_valid,
  input  logic                                                     i_blk_ready,
  output logic signed [MCU_SIZE-1:0][MCU_SIZE-1:0][QUAN_BITWIDTH-1:0] o_blk_data,
  output logic [1:0]                                               o_blk_comp,
  output logic                                                     o_blk_last,
  output logic [MCU_CNT_WIDTH-1:0]                                 o_mcu_idx
);

  typedef enum logic [1:0] {IDLE, SEND_Y, SEND_U, SEND_V} state_t;

  state_t r_state, w_next;
  logic signed [MCU_SIZE-1:0][MCU_SIZE-1:0][QUAN_BITWIDTH-1:0] r_ybuf, r_ubuf, r_vbuf;
  logic                     r_last_buf;
  logic [MCU_CNT_WIDTH-1:0] r_mcu_cnt;
  logic                     w_v_done;
  logic                     w_cap;

  // The slot frees up in the same cycle the V block leaves, so a new triple can
  // be captured then and the stream runs at 3 cycles per MCU with no bubble.
  assign w_v_done = (r_state == SEND_V) && i_blk_ready;
  assign w_cap    = i_quan_valid && ((r_state == IDLE) || w_v_done);
  assign o_wait   = !((r_state == IDLE) || w_v_done);

  always_ff @(posedge clk) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (w_cap)       w_next = SEND_Y;
      SEND_Y: if (i_blk_ready) w_next = SEND_U;
      SEND_U: if (i_blk_ready) w_next = SEND_V;
      SEND_V: if (i_blk_ready) w_next = w_cap ? SEND_Y : IDLE;
      default:                 w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_ybuf     <= '0;
      r_ubuf     <= '0;
      r_vbuf     <= '0;
      r_last_buf <= 1'b0;
    end else if (w_cap) begin
      r_ybuf     <= i_quan_y;
      r_ubuf     <= i_quan_u;
      r_vbuf     <= i_quan_v;
      r_last_buf <= i_last;
    end
  end

  // Index advances when the V block of an MCU leaves; the last MCU of an image
  // restarts numbering for the next image.
  always_ff @(posedge clk) begin
    if (!n_rst)        r_mcu_cnt <= '0;
    else if (w_v_done) r_mcu_cnt <= r_last_buf ? '0 : r_mcu_cnt + 1'b1;
  end

  always_comb begin
    o_blk_valid = 1'b0;
    o_blk_data  = '0;
    o_blk_comp  = 2'd0;
    o_blk_last  = 1'b0;
    case (r_state)
      SEND_Y: begin
        o_blk_valid = 1'b1;
        o_blk_data  = r_ybuf;
        o_blk_comp  = 2'd0;
      end
      SEND_U: begin
        o_blk_valid = 1'b1;
        o_blk_data  = r_ubuf;
        o_blk_comp  = 2'd1;
      end
      SEND_V: begin
        o_blk_valid = 1'b1;
        o_blk_data  = r_vbuf;
        o_blk_comp  = 2'd2;
        o_blk_last  = r_last_buf;
      end
      default: ;
    endcase
  end

  assign o_mcu_idx = r_mcu_cnt;

endmodule

// File: tb/tb_quan_block_scheduler.sv
module tb_quan_block_scheduler;
  localparam int BW = 768;  // 8*8*12 bits per block

  logic clk = 1'b0;
  logic n_rst, i_quan_valid, i_last, i_blk_ready;
  logic signed [7:0][7:0][11:0] i_quan_y, i_quan_u, i_quan_v, o_blk_data;
  logic o_wait, o_blk_valid, o_blk_last;
  logic [1:0] o_blk_comp, o_mcu_idx;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  quan_block_scheduler #(.MCU_SIZE(8), .QUAN_BITWIDTH(12), .MCU_CNT_WIDTH(2)) dut (
    .clk(clk), .n_rst(n_rst), .i_quan_valid(i_quan_valid),
    .i_quan_y(i_quan_y), .i_quan_u(i_quan_u), .i_quan_v(i_quan_v),
    .i_last(i_last), .o_wait(o_wait), .o_blk_valid(o_blk_valid),
    .i_blk_ready(i_blk_ready), .o_blk_data(o_blk_data), .o_blk_comp(o_blk_comp),
    .o_blk_last(o_blk_last), .o_mcu_idx(o_mcu_idx)
  );

  function automatic logic [BW-1:0] rep(input int v);
    logic [BW-1:0] r;
    logic [11:0]   c;
    c = v[11:0];
    for (int k = 0; k < 64; k++) r[k*12 +: 12] = c;
    return r;
  endfunction

  function automatic logic [BW-1:0] rnd();
    logic [BW-1:0] r;
    for (int k = 0; k < 24; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mcu(input int v);
    i_quan_y = rep(v);
    i_quan_u = rep(v + 1);
    i_quan_v = rep(v + 2);
  endtask

  typedef struct {
    logic rst, qv, ql; int val; logic rdy;
    logic ev; int ec; logic el, ew; int ei, ed;
  } row_t;

  row_t tbl[$];

  function automatic row_t mk(logic rst, logic qv, logic ql, int val, logic rdy,
                              logic ev, int ec, logic el, logic ew, int ei, int ed);
    row_t r;
    r.rst = rst; r.qv = qv; r.ql = ql; r.val = val; r.rdy = rdy;
    r.ev = ev; r.ec = ec; r.el = el; r.ew = ew; r.ei = ei; r.ed = ed;
    return r;
  endfunction

  // behavioural reference: a queue of pending blocks plus the MCU counter
  typedef struct { logic [BW-1:0] d; logic [1:0] c; logic l; } mblk_t;
  mblk_t mq[$];
  int    mcnt;

  initial begin
    n_rst = 1'b0; i_quan_valid = 1'b0; i_last = 1'b0; i_blk_ready = 1'b1;
    set_mcu(0);
    tick(); tick();

    //        rst qv ql val  rdy  ev ec el ew ei ed
    // reset state, then one MCU
    tbl.push_back(mk(1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 1,   1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,   1, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0,   1, 1, 1, 0, 1, 0, 2));
    tbl.push_back(mk(1, 0, 0, 0,   1, 1, 2, 0, 0, 0, 3));
    tbl.push_back(mk(1, 0, 0, 0,   1, 0, 0, 0, 0, 1, 0));
    // back-to-back 4 MCUs (index wraps 3 -> 0)
    tbl.push_back(mk(1, 1, 0, 10,  1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 20,  1, 1, 0, 0, 1, 1, 10));
    tbl.push_back(mk(1, 1, 0, 20,  1, 1, 1, 0, 1, 1, 11));
    tbl.push_back(mk(1, 1, 0, 20,  1, 1, 2, 0, 0, 1, 12));
    tbl.push_back(mk(1, 1, 0, 30,  1, 1, 0, 0, 1, 2, 20));
    tbl.push_back(mk(1, 1, 0, 30,  1, 1, 1, 0, 1, 2, 21));
    tbl.push_back(mk(1, 1, 0, 30,  1, 1, 2, 0, 0, 2, 22));
    tbl.push_back(mk(1, 1, 0, 40,  1, 1, 0, 0, 1, 3, 30));
    tbl.push_back(mk(1, 1, 0, 40,  1, 1, 1, 0, 1, 3, 31));
    tbl.push_back(mk(1, 1, 0, 40,  1, 1, 2, 0, 0, 3, 32));
    tbl.push_back(mk(1, 0, 0, 0,   1, 1, 0, 0, 1, 0, 40));
    tbl.push_back(mk(1, 0, 0, 0,   1, 1, 1, 0, 1, 0, 41));
    tbl.push_back(mk(1, 0, 0, 0,   1, 1, 2, 0, 0, 0, 42));
    tbl.push_back(mk(1, 0, 0, 0,   1, 0, 0, 0, 0, 1, 0));
    // backpressure during SEND_U and SEND_V, next MCU held at the input
    tbl.push_back(mk(1, 1, 0, 100, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 200, 1, 1, 0, 0, 1, 1, 100));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 1, 0, 200, 0, 1, 1, 0, 1, 1, 101));
    tbl.push_back(mk(1, 1, 0, 200, 1, 1, 1, 0, 1, 1, 101));
    tbl.push_back(mk(1, 1, 0, 200, 0, 1, 2, 0, 1, 1, 102));
    tbl.push_back(mk(1, 1, 0, 200, 1, 1, 2, 0, 0, 1, 102));
    tbl.push_back(mk(1, 0, 0, 0,   1, 1, 0, 0, 1, 2, 200));
    tbl.push_back(mk(1, 0, 0, 0,   1, 1, 1, 0, 1, 2, 201));
    tbl.push_back(mk(1, 0, 0, 0,   1, 1, 2, 0, 0, 2, 202));
    tbl.push_back(mk(1, 0, 0, 0,   1, 0, 0, 0, 0, 3, 0));
    // last MCU: o_blk_last only on its V, index restarts
    tbl.push_back(mk(1, 1, 1, 50,  1, 0, 0, 0, 0, 3, 0));
    tbl.push_back(mk(1, 1, 0, 60,  1, 1, 0, 0, 1, 3, 50));
    tbl.push_back(mk(1, 1, 0, 60,  1, 1, 1, 0, 1, 3, 51));
    tbl.push_back(mk(1, 1, 0, 60,  1, 1, 2, 1, 0, 3, 52));
    tbl.push_back(mk(1, 0, 0, 0,   1, 1, 0, 0, 1, 0, 60));
    tbl.push_back(mk(1, 0, 0, 0,   1, 1, 1, 0, 1, 0, 61));
    tbl.push_back(mk(1, 0, 0, 0,   1, 1, 2, 0, 0, 0, 62));
    tbl.push_back(mk(1, 0, 0, 0,   1, 0, 0, 0, 0, 1, 0));
    // reset during SEND_U discards the triple
    tbl.push_back(mk(1, 1, 0, 70,  1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0,   1, 1, 0, 0, 1, 1, 70));
    tbl.push_back(mk(0, 0, 0, 0,   1, 1, 1, 0, 1, 1, 71));
    tbl.push_back(mk(1, 1, 0, 80,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,   1, 1, 0, 0, 1, 0, 80));
    tbl.push_back(mk(1, 0, 0, 0,   1, 1, 1, 0, 1, 0, 81));
    tbl.push_back(mk(1, 0, 0, 0,   1, 1, 2, 0, 0, 0, 82));
    tbl.push_back(mk(1, 0, 0, 0,   1, 0, 0, 0, 0, 1, 0));

    foreach (tbl[i]) begin
      n_rst = tbl[i].rst; i_quan_valid = tbl[i].qv; i_last = tbl[i].ql;
      i_blk_ready = tbl[i].rdy; set_mcu(tbl[i].val);
      @(negedge clk);
      chk($sformatf("row%0d valid", i), BW'(o_blk_valid), BW'(tbl[i].ev));
      chk($sformatf("row%0d comp", i),  BW'(o_blk_comp),  BW'(tbl[i].ec));
      chk($sformatf("row%0d last", i),  BW'(o_blk_last),  BW'(tbl[i].el));
      chk($sformatf("row%0d wait", i),  BW'(o_wait),      BW'(tbl[i].ew));
      chk($sformatf("row%0d idx", i),   BW'(o_mcu_idx),   BW'(tbl[i].ei));
      chk($sformatf("row%0d data", i),  o_blk_data,       rep(tbl[i].ed));
      tick();
    end

    // counter wrap: 5 MCUs without last give idx 0,1,2,3,0
    n_rst = 1'b0; i_quan_valid = 1'b0; i_last = 1'b0; i_blk_ready = 1'b1;
    tick();
    n_rst = 1'b1; i_quan_valid = 1'b1; set_mcu(8);
    @(negedge clk);
    chk("wrap start wait", BW'(o_wait), BW'(0));
    tick();
    for (int m = 0; m < 5; m++) begin
      for (int c = 0; c < 3; c++) begin
        i_quan_valid = (m < 4);
        set_mcu((m + 2) * 8);
        @(negedge clk);
        chk($sformatf("wrap m%0d c%0d comp", m, c), BW'(o_blk_comp), BW'(c));
        chk($sformatf("wrap m%0d c%0d idx", m, c),  BW'(o_mcu_idx),  BW'(m % 4));
        chk($sformatf("wrap m%0d c%0d data", m, c), o_blk_data,      rep((m + 1) * 8 + c));
        tick();
      end
    end

    // randomized traffic against the queue model
    n_rst = 1'b0; i_quan_valid = 1'b0; i_last = 1'b0; i_blk_ready = 1'b0;
    tick();
    n_rst = 1'b1;
    mq.delete();
    mcnt = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      logic ev, ew, cap, xf;
      mblk_t b;
      @(negedge clk);
      ev = (mq.size() != 0);
      ew = !(mq.size() == 0 || (mq.size() == 1 && i_blk_ready));
      chk("rnd valid", BW'(o_blk_valid), BW'(ev));
      chk("rnd wait",  BW'(o_wait),      BW'(ew));
      chk("rnd idx",   BW'(o_mcu_idx),   BW'(mcnt));
      if (ev) begin
        chk("rnd data", o_blk_data,       mq[0].d);
        chk("rnd comp", BW'(o_blk_comp),  BW'(mq[0].c));
        chk("rnd last", BW'(o_blk_last),  BW'(mq[0].l));
      end else begin
        chk("rnd idle data", o_blk_data, '0);
        chk("rnd idle last", BW'(o_blk_last), BW'(0));
      end
      cap = i_quan_valid && !ew;
      xf  = ev && i_blk_ready;
      if (xf) begin
        b = mq.pop_front();
        if (b.c == 2) mcnt = b.l ? 0 : (mcnt + 1) % 4;
      end
      if (cap) begin
        mq.push_back('{d: i_quan_y, c: 2'd0, l: 1'b0});
        mq.push_back('{d: i_quan_u, c: 2'd1, l: 1'b0});
        mq.push_back('{d: i_quan_v, c: 2'd2, l: i_last});
      end
      tick();
      i_blk_ready = ($urandom_range(9) < 7);
      if (!(i_quan_valid && !cap)) begin
        i_quan_valid = ($urandom_range(9) < 6);
        i_last       = ($urandom_range(3) == 0);
        i_quan_y     = rnd();
        i_quan_u     = rnd();
        i_quan_v     = rnd();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/quan_block_scheduler.md
Name: quan_block_scheduler

Overview:
Sits between yuv_quantizer and the zigzag/entropy-coder stage. Captures one quantized Y/U/V MCU triple per quantizer valid and serialises it as three single-block transfers, in Y, U, V order, over a valid/ready handshake. Drives the quantizer's i_wait to stall the upstream pipeline while its single-slot buffer is occupied. Tags each block with its component ID, the MCU index and the end-of-image flag.

Parameters:
MCU_SIZE, 8, block edge length (MCU_SIZE x MCU_SIZE coefficients per component)
QUAN_BITWIDTH, 12, signed bit width of each quantized coefficient
MCU_CNT_WIDTH, 16, width of the MCU index counter

Ports:
clk  in  1  clock
n_rst  in  1  reset, synchronous, active-low
i_quan_valid  in  1  quantizer output valid; held stable by the quantizer while o_wait=1
i_quan_y  in  signed [MCU_SIZE-1:0][MCU_SIZE-1:0][QUAN_BITWIDTH-1:0]  quantized Y block
i_quan_u  in  same as i_quan_y  quantized U block
i_quan_v  in  same as i_quan_y  quantized V block
i_last  in  1  current MCU is the last of the image; qualified by i_quan_valid
o_wait  out  1  stall to the quantizer's i_wait
o_blk_valid  out  1  output block valid
i_blk_ready  in  1  downstream accepts the block
o_blk_data  out  signed [MCU_SIZE-1:0][MCU_SIZE-1:0][QUAN_BITWIDTH-1:0]  output block
o_blk_comp  out  2  component ID: 0=Y, 1=U, 2=V
o_blk_last  out  1  final block of the image (V of the last MCU)
o_mcu_idx  out  MCU_CNT_WIDTH  index of the MCU currently presented

Behaviour:
- Reset (n_rst=0 at a clk edge):
  - state=IDLE; Y/U/V buffers and last_buf cleared to 0; mcu counter=0.
  - Resulting outputs: o_blk_valid=0, o_blk_data=0, o_blk_comp=0, o_blk_last=0, o_mcu_idx=0, o_wait=0.
  - Reset mid-transfer discards the buffered MCU; no partial triple is resumed.
- FSM states: IDLE, SEND_Y, SEND_U, SEND_V. State is registered.
- cap (capture condition) = i_quan_valid && (state==IDLE || (state==SEND_V && i_blk_ready)).
- On cap:
  - Register i_quan_y/u/v into the buffers and i_last into last_buf.
  - Next state = SEND_Y.
- Transitions:
  - IDLE -> SEND_Y on cap; otherwise stay in IDLE.
  - SEND_Y -> SEND_U on i_blk_ready; otherwise hold.
  - SEND_U -> SEND_V on i_blk_ready; otherwise hold.
  - SEND_V with i_blk_ready -> SEND_Y if cap, else IDLE.
  - SEND_V without i_blk_ready -> hold.
- o_wait = !(state==IDLE || (state==SEND_V && i_blk_ready)).
  - Combinational path from i_blk_ready; implementer keeps this path registered-input-only, with no other logic on it.
  - o_wait=0 in a cycle with i_quan_valid=1 means the triple is captured in that cycle. The quantizer advances only then, so no MCU is lost or duplicated.
- Output decode (combinational from state and buffers):
  - o_blk_valid = (state != IDLE).
  - o_blk_data = Ybuf/Ubuf/Vbuf for SEND_Y/U/V; 0 in IDLE.
  - o_blk_comp = 0/1/2 for SEND_Y/U/V; 0 in IDLE.
  - o_blk_last = last_buf && state==SEND_V.
- Handshake rules:
  - Transfer occurs when o_blk_valid && i_blk_ready.
  - While valid and not ready, data, comp, last and idx are stable.
  - o_blk_valid never drops without a transfer, except on reset.
- MCU counter:
  - On a V transfer: cleared to 0 if last_buf, else incremented by 1.
  - Wraps modulo 2^MCU_CNT_WIDTH.
  - o_mcu_idx = counter value.
- Throughput and latency:
  - 3 cycles per MCU with continuous ready and valid.
  - First block is valid 1 cycle after the capture cycle.
- Data is passed bit-exact; there is no arithmetic on coefficients.

Test Plan:
- Reset then one MCU (Y all 1, U all 2, V all 3, i_last=0), ready=1:
  - o_blk_valid high for 3 cycles, comp 0,1,2, data 1/2/3.
  - o_mcu_idx=0 throughout, then 1 after the V transfer.
  - o_wait=1 during SEND_Y and SEND_U.
- Back-to-back: 4 MCUs valid every cycle, ready=1:
  - 12 consecutive valid cycles with no bubble.
  - o_wait pattern per MCU is 1,1,0.
  - idx sequence 0..3.
- Backpressure: ready=0 for 5 cycles during SEND_U:
  - comp=1 and data held for 5 cycles.
  - o_wait held at 1; the quantizer input is not consumed.
  - Transfer completes when ready returns.
- Last handling: MCU 2 carries i_last=1:
  - o_blk_last=1 only on its V block.
  - o_mcu_idx returns to 0 for the next MCU.
- Reset asserted during SEND_U:
  - Next cycle: o_blk_valid=0, o_wait=0, idx=0.
  - The following MCU is emitted starting with comp=0.
- Counter wrap with MCU_CNT_WIDTH=2:
  - 5 MCUs without last give idx 0,1,2,3,0.
